// File: rtl/sprite_ram_arbiter_if.sv
// Sprite attribute RAM bus: display read port, packed logic-client ports
// and the single RAM port. slave = arbiter side, master = clients + RAM side.
interface sprite_ram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REQ    = 2
);
    logic                          disp_req;
    logic [ADDR_WIDTH-1:0]         disp_addr;
    logic [DATA_WIDTH-1:0]         disp_data;
    logic                          disp_valid;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [NUM_REQ-1:0]            rvalid;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic                          mem_we;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport slave (
        input  disp_req, disp_addr, req, lock, req_we,
        input  req_addr, req_wdata, mem_rdata,
        output disp_data, disp_valid, gnt, rdata, rvalid,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output disp_req, disp_addr, req, lock, req_we,
        output req_addr, req_wdata, mem_rdata,
        input  disp_data, disp_valid, gnt, rdata, rvalid,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/sprite_ram_arbiter.sv
// Single-port sprite RAM arbiter: display reads win outright, logic clients
// round-robin with a lock for read-modify-write.
// Ports: clk, reset (async, active low), bus (sprite_ram_arbiter_if.slave).
module sprite_ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REQ    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_ram_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      owner, owner_n;
    logic [PW-1:0]      sel, cand;
    logic               sel_vld;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid_q;
    logic               disp_valid_q;

    // Winner selection; display cycles select nobody.
    always_comb begin
        sel     = '0;
        cand    = '0;
        sel_vld = 1'b0;
        if (!bus.disp_req) begin
            unique case (state)
                ARB: begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
                        if (!sel_vld && bus.req[cand]) begin
                            sel_vld = 1'b1;
                            sel     = cand;
                        end
                    end
                end
                LOCKED: begin
                    if (bus.req[owner]) begin
                        sel_vld = 1'b1;
                        sel     = owner;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced idle while reset is held, not just after an edge.
    always_comb begin
        gnt           = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (reset) begin
            if (bus.disp_req) begin
                bus.mem_addr = bus.disp_addr;
            end else if (sel_vld) begin
                gnt           = NUM_REQ'(1) << sel;
                bus.mem_addr  = bus.req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                bus.mem_wdata = bus.req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                bus.mem_we    = bus.req_we[sel];
            end
        end
    end

    // Lock release is seen in the same cycle it is arbitrated owner-only.
    always_comb begin
        state_n = state;
        owner_n = owner;
        unique case (state)
            ARB: begin
                if (sel_vld && bus.lock[sel]) begin
                    state_n = LOCKED;
                    owner_n = sel;
                end
            end
            LOCKED: begin
                if (!bus.lock[owner]) state_n = ARB;
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB;
            rr_ptr       <= PW'(NUM_REQ - 1);
            owner        <= '0;
            rvalid_q     <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            if (state == ARB && sel_vld) rr_ptr <= sel;
            rvalid_q     <= gnt & ~bus.req_we;
            disp_valid_q <= bus.disp_req;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.rvalid     = rvalid_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.rdata      = bus.mem_rdata;
    assign bus.disp_data  = bus.mem_rdata;
endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter with a small synchronous RAM model.
// Inputs change just after negedge; outputs checked 1 ns later.
module tb_sprite_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    logic [15:0] ram [0:255];

    sprite_ram_arbiter_if #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_REQ(2)
    ) bus ();

    sprite_ram_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_REQ(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        if (bus.mem_we) ram[bus.mem_addr[7:0]] = bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] g, input logic [1:0] rv);
        #1;
        chk("gnt", 16'(bus.gnt), 16'(g));
        chk("rvalid", 16'(bus.rvalid), 16'(rv));
    endtask

    task automatic mem(input logic [15:0] a, input logic we,
                       input logic [15:0] wd);
        chk("mem_addr", bus.mem_addr, a);
        chk("mem_we", 16'(bus.mem_we), 16'(we));
        chk("mem_wdata", bus.mem_wdata, wd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[8'h00] = 16'd100;
        ram[8'h02] = 16'd200;
        ram[8'h04] = 16'd300;
        ram[8'h06] = 16'd400;

        reset         = 1'b0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = 16'h0;
        bus.req       = 2'b00;
        bus.lock      = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = {16'h1002, 16'h1000};
        bus.req_wdata = 32'h0;

        // reset state
        @(negedge clk);
        cyc(2'b00, 2'b00);
        chk("disp_valid_rst", 16'(bus.disp_valid), 16'h0);
        mem(16'h0, 1'b0, 16'h0);

        // reset mid-read
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 2'b01;
        cyc(2'b01, 2'b00);
        mem(16'h1000, 1'b0, 16'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("gnt_in_rst", 16'(bus.gnt), 16'h0);
        mem(16'h0, 1'b0, 16'h0);
        @(negedge clk);
        chk("rvalid_after_rst", 16'(bus.rvalid), 16'h0);

        // round-robin after release, client 0 first
        reset   = 1'b1;
        bus.req = 2'b11;
        cyc(2'b01, 2'b00);
        @(negedge clk);
        cyc(2'b10, 2'b01);
        chk("rr_rdata0", bus.rdata, 16'd100);
        chk("rr_addr1", bus.mem_addr, 16'h1002);
        @(negedge clk);
        cyc(2'b01, 2'b10);
        chk("rr_rdata1", bus.rdata, 16'd200);
        @(negedge clk);
        cyc(2'b10, 2'b01);

        // display priority, three cycles
        @(negedge clk);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h1004;
        cyc(2'b00, 2'b10);
        mem(16'h1004, 1'b0, 16'h0);
        chk("disp_valid_0", 16'(bus.disp_valid), 16'h0);
        @(negedge clk);
        cyc(2'b00, 2'b00);
        chk("disp_valid_1", 16'(bus.disp_valid), 16'h1);
        chk("disp_data_1", bus.disp_data, 16'd300);
        @(negedge clk);
        cyc(2'b00, 2'b00);
        chk("disp_valid_2", 16'(bus.disp_valid), 16'h1);
        @(negedge clk);
        bus.disp_req = 1'b0;
        cyc(2'b01, 2'b00);
        chk("disp_valid_3", 16'(bus.disp_valid), 16'h1);
        chk("disp_data_3", bus.disp_data, 16'd300);
        @(negedge clk);
        bus.req = 2'b10;
        cyc(2'b10, 2'b01);
        chk("disp_valid_end", 16'(bus.disp_valid), 16'h0);
        chk("rdata_after_disp", bus.rdata, 16'd100);

        // read-modify-write under lock
        @(negedge clk);
        bus.req  = 2'b11;
        bus.lock = 2'b01;
        cyc(2'b01, 2'b10);
        @(negedge clk);
        bus.req_we    = 2'b01;
        bus.req_wdata = {16'h0, 16'd104};
        cyc(2'b01, 2'b01);
        chk("rmw_fetch", bus.rdata, 16'd100);
        mem(16'h1000, 1'b1, 16'd104);
        @(negedge clk);
        bus.req    = 2'b10;
        bus.lock   = 2'b00;
        bus.req_we = 2'b00;
        cyc(2'b00, 2'b00);
        mem(16'h0, 1'b0, 16'h0);

        // client 1 takes ownership
        @(negedge clk);
        bus.lock = 2'b10;
        cyc(2'b10, 2'b00);

        // display preempts a lock
        @(negedge clk);
        bus.req       = 2'b11;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h1006;
        cyc(2'b00, 2'b10);
        mem(16'h1006, 1'b0, 16'h0);
        @(negedge clk);
        bus.disp_req = 1'b0;
        cyc(2'b10, 2'b00);
        chk("lock_disp_data", bus.disp_data, 16'd400);

        // write path: client 1 writes 0x1002=3 while releasing lock
        @(negedge clk);
        bus.lock      = 2'b00;
        bus.req_we    = 2'b10;
        bus.req_wdata = {16'd3, 16'h0};
        cyc(2'b10, 2'b10);
        mem(16'h1002, 1'b1, 16'd3);
        @(negedge clk);
        bus.req      = 2'b01;
        bus.req_we   = 2'b00;
        bus.req_addr = {16'h1002, 16'h1002};
        cyc(2'b01, 2'b00);
        chk("we_one_cycle", 16'(bus.mem_we), 16'h0);
        @(negedge clk);
        bus.req_addr = {16'h1002, 16'h1000};
        cyc(2'b01, 2'b01);
        chk("write_readback", bus.rdata, 16'd3);
        @(negedge clk);
        bus.req = 2'b00;
        cyc(2'b00, 2'b01);
        chk("rmw_result", bus.rdata, 16'd104);
        mem(16'h0, 1'b0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
